// File: rtl/gpu_write_scheduler.sv
// Frame-synchronous write scheduler: queues cluster register writes and
// releases them during vertical blanking (or continuously in immediate mode).
module gpu_write_scheduler #(
  parameter int unsigned ADDR_WIDTH   = 24,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FIFO_DEPTH   = 64,
  parameter int unsigned DRAIN_BUDGET = 64000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [ADDR_WIDTH-1:0]         in_waddr,
  input  logic [DATA_WIDTH-1:0]         in_wdata,
  input  logic                          in_wen,
  output logic                          in_ready,
  input  logic                          vsync,
  input  logic                          immediate,
  output logic [ADDR_WIDTH-1:0]         out_waddr,
  output logic [DATA_WIDTH-1:0]         out_wdata,
  output logic                          out_wen,
  output logic                          texture_lock,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned IW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = $clog2(DRAIN_BUDGET + 1);
  localparam int unsigned EW = ADDR_WIDTH + DATA_WIDTH;

  typedef enum logic {COLLECT, DRAIN} state_t;

  state_t          state;
  logic [BW-1:0]   budget;
  logic            last_vsync;
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [IW:0]     wr_ptr, rd_ptr, level;
  logic            full, empty, push, pop, vsync_fall;
  logic [EW-1:0]   head;

  assign level      = wr_ptr - rd_ptr;
  assign full       = (level == (IW+1)'(FIFO_DEPTH));
  assign empty      = (wr_ptr == rd_ptr);
  // Readiness depends only on occupancy, so a same-cycle pop never opens a full FIFO.
  assign in_ready   = !full;
  assign push       = in_wen && !full;
  assign vsync_fall = !vsync && last_vsync;
  assign fifo_level = level;
  assign head       = mem[rd_ptr[IW-1:0]];

  always_comb begin
    pop = 1'b0;
    case (state)
      COLLECT: pop = immediate && !empty;
      DRAIN:   pop = !empty;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[IW-1:0]] <= {in_waddr, in_wdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (IW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (IW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= COLLECT;
      budget       <= '0;
      last_vsync   <= 1'b1;
      out_waddr    <= '0;
      out_wdata    <= '0;
      out_wen      <= 1'b0;
      texture_lock <= 1'b0;
    end else begin
      last_vsync   <= vsync;
      texture_lock <= (state == DRAIN);
      out_wen      <= pop;
      if (pop) {out_waddr, out_wdata} <= head;
      case (state)
        COLLECT: begin
          if (vsync_fall && !immediate && !empty) begin
            state  <= DRAIN;
            budget <= '0;
          end
        end
        DRAIN: begin
          budget <= budget + BW'(1);
          // Budget exit still pops on its final cycle; empty exit does not.
          if (empty || budget == BW'(DRAIN_BUDGET - 1)) state <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_gpu_write_scheduler.sv
// Directed bench for gpu_write_scheduler: default instance plus a
// DRAIN_BUDGET=4 instance sharing the same stimulus.
module tb_gpu_write_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] in_waddr;
  logic [31:0] in_wdata;
  logic        in_wen, vsync, immediate;

  logic        a_in_ready, a_out_wen, a_lock;
  logic [23:0] a_out_waddr;
  logic [31:0] a_out_wdata;
  logic [6:0]  a_level;

  logic        b_in_ready, b_out_wen, b_lock;
  logic [23:0] b_out_waddr;
  logic [31:0] b_out_wdata;
  logic [6:0]  b_level;

  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [55:0] a_q[$];
  int unsigned b_cnt = 0;

  always #10 clk = ~clk;

  gpu_write_scheduler dut (
    .clk(clk), .rst_n(rst_n), .in_waddr(in_waddr), .in_wdata(in_wdata),
    .in_wen(in_wen), .in_ready(a_in_ready), .vsync(vsync), .immediate(immediate),
    .out_waddr(a_out_waddr), .out_wdata(a_out_wdata), .out_wen(a_out_wen),
    .texture_lock(a_lock), .fifo_level(a_level)
  );

  gpu_write_scheduler #(.DRAIN_BUDGET(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_waddr(in_waddr), .in_wdata(in_wdata),
    .in_wen(in_wen), .in_ready(b_in_ready), .vsync(vsync), .immediate(immediate),
    .out_waddr(b_out_waddr), .out_wdata(b_out_wdata), .out_wen(b_out_wen),
    .texture_lock(b_lock), .fifo_level(b_level)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock edge; outputs are sampled 1 ns after it and pulses are logged.
  task automatic step();
    @(posedge clk);
    #1;
    if (a_out_wen) a_q.push_back({a_out_waddr, a_out_wdata});
    if (b_out_wen) b_cnt++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_wen = 1'b0;
    vsync = 1'b1;
    #7;
    rst_n = 1'b1;
    step();
  endtask

  task automatic write(input logic [23:0] a, input logic [31:0] d);
    in_waddr = a;
    in_wdata = d;
    in_wen   = 1'b1;
    step();
    in_wen   = 1'b0;
  endtask

  initial begin
    int errs;
    int guard;
    rst_n = 1'b0; in_waddr = '0; in_wdata = '0; in_wen = 1'b0;
    vsync = 1'b1; immediate = 1'b0;
    #5;
    check("rst_out_wen", 64'(a_out_wen), 64'd0);
    check("rst_lock", 64'(a_lock), 64'd0);
    check("rst_level", 64'(a_level), 64'd0);
    check("rst_in_ready", 64'(a_in_ready), 64'd1);
    check("rst_addr_data", {8'h0, a_out_waddr, a_out_wdata}, 64'd0);
    #3 rst_n = 1'b1;
    step();

    // Three queued writes, no vblank yet
    write(24'h10, 32'hA);
    write(24'h14, 32'hB);
    write(24'h18, 32'hC);
    step();
    check("collect_level", 64'(a_level), 64'd3);
    check("collect_no_wen", 64'(a_q.size()), 64'd0);

    // Vblank drain, cycle-exact
    vsync = 1'b0;
    step();
    check("drain_T_wen", 64'(a_out_wen), 64'd0);
    check("drain_T_lock", 64'(a_lock), 64'd0);
    vsync = 1'b1;
    step();
    check("drain_A", {a_out_wen, a_lock, a_out_waddr, a_out_wdata}, {2'b11, 24'h10, 32'hA});
    step();
    check("drain_B", {a_out_wen, a_lock, a_out_waddr, a_out_wdata}, {2'b11, 24'h14, 32'hB});
    step();
    check("drain_C", {a_out_wen, a_lock, a_out_waddr, a_out_wdata}, {2'b11, 24'h18, 32'hC});
    check("drain_level", 64'(a_level), 64'd0);
    step();
    check("drain_tail", {a_out_wen, a_lock}, 64'b01);
    step();
    check("drain_unlock", {a_out_wen, a_lock}, 64'b00);

    // Fill to 64, hold a 65th write through the vblank
    a_q.delete();
    for (int i = 0; i < 64; i++) write(24'h100 + 24'(4 * i), 32'(i));
    check("full_level", 64'(a_level), 64'd64);
    check("full_not_ready", 64'(a_in_ready), 64'd0);
    in_waddr = 24'h200; in_wdata = 32'h40; in_wen = 1'b1;
    step();
    step();
    check("full_hold_level", 64'(a_level), 64'd64);
    vsync = 1'b0;
    step();
    check("full_T_level", 64'(a_level), 64'd64);
    vsync = 1'b1;
    step();
    check("full_first_pop", {a_out_wen, a_out_waddr, a_out_wdata}, {1'b1, 24'h100, 32'h0});
    check("full_refused_on_pop", 64'(a_level), 64'd63);
    check("full_ready_after_pop", 64'(a_in_ready), 64'd1);
    step();
    check("full_accept_next", 64'(a_level), 64'd63);
    in_wen = 1'b0;
    guard = 0;
    while ((a_q.size() < 65 || a_out_wen) && guard < 200) begin
      step();
      guard++;
    end
    check("full_drain_timeout", 64'(guard < 200), 64'd1);
    check("full_count", 64'(a_q.size()), 64'd65);
    errs = 0;
    for (int i = 0; i < a_q.size() && i < 65; i++) begin
      if (i < 64) begin
        if (a_q[i] !== {24'h100 + 24'(4 * i), 32'(i)}) errs++;
      end else if (a_q[i] !== {24'h200, 32'h40}) errs++;
    end
    check("full_order", 64'(errs), 64'd0);
    step(); step();
    check("full_end", {a_lock, 7'(a_level)}, 64'd0);

    // DRAIN_BUDGET=4 instance
    do_reset();
    for (int i = 0; i < 10; i++) write(24'h300 + 24'(i), 32'h50 + 32'(i));
    check("budget_level_q", 64'(b_level), 64'd10);
    b_cnt = 0;
    vsync = 1'b0;
    step();
    vsync = 1'b1;
    for (int i = 0; i < 9; i++) step();
    check("budget_pulses1", 64'(b_cnt), 64'd4);
    check("budget_level1", 64'(b_level), 64'd6);
    check("budget_lock1", 64'(b_lock), 64'd0);
    vsync = 1'b0;
    step();
    vsync = 1'b1;
    for (int i = 0; i < 9; i++) step();
    check("budget_pulses2", 64'(b_cnt), 64'd8);
    check("budget_level2", 64'(b_level), 64'd2);
    check("budget_last_data", 64'(b_out_wdata), 64'h57);

    // Immediate mode with vsync toggling
    do_reset();
    immediate = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_waddr = 24'h400 + 24'(k);
      in_wdata = 32'h60 + 32'(k);
      in_wen   = 1'b1;
      vsync    = (k % 2 == 1) ? 1'b0 : 1'b1;
      step();
      check("imm_level", 64'(a_level), 64'd1);
      check("imm_lock", 64'(a_lock), 64'd0);
      check("imm_wen", 64'(a_out_wen), (k > 0) ? 64'd1 : 64'd0);
      if (k > 0)
        check("imm_data", {a_out_waddr, a_out_wdata}, {24'h400 + 24'(k - 1), 32'h60 + 32'(k - 1)});
    end
    in_wen = 1'b0;
    vsync  = 1'b1;
    step();
    check("imm_last", {a_out_wen, a_out_waddr, a_out_wdata, 7'(a_level)}, {1'b1, 24'h404, 32'h64, 7'd0});
    step();
    check("imm_idle", {a_out_wen, a_lock}, 64'b00);

    // Reset mid-drain
    immediate = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) write(24'h500 + 24'(i), 32'h70 + 32'(i));
    vsync = 1'b0;
    step();
    vsync = 1'b1;
    step();
    check("mid_pre", {a_out_wen, a_lock, 7'(a_level)}, {2'b11, 7'd4});
    #5 rst_n = 1'b0;
    #1;
    check("mid_async", {a_out_wen, a_lock, 7'(a_level)}, 64'd0);
    check("mid_async_addr", 64'(a_out_waddr), 64'd0);
    step();
    #3 rst_n = 1'b1;
    step();
    check("mid_post", {a_in_ready, a_out_wen, a_lock, 7'(a_level)}, {3'b100, 7'd0});
    a_q.delete();
    vsync = 1'b0;
    step();
    vsync = 1'b1;
    step(); step();
    check("mid_empty_fall", {a_out_wen, a_lock}, 64'b00);
    write(24'h600, 32'h99);
    step(); step();
    check("mid_collect_level", 64'(a_level), 64'd1);
    check("mid_collect_no_wen", 64'(a_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
